// File: rtl/montgomery_mul_pipe_hs_if.sv
// rtl/montgomery_mul_pipe_hs_if.sv - handshake bundle for the Montgomery multiplier
interface montgomery_mul_pipe_hs_if #(
    parameter int COEFF_WIDTH = 31,
    parameter int TAG_WIDTH   = 8
);
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_mode;
    logic signed [COEFF_WIDTH-1:0] in_op1;
    logic signed [COEFF_WIDTH-1:0] in_op2;
    logic [TAG_WIDTH-1:0]          in_tag;
    logic                          out_valid;
    logic                          out_ready;
    logic [COEFF_WIDTH-1:0]        out_result;
    logic [TAG_WIDTH-1:0]          out_tag;
    logic                          busy;

    // Producer/consumer side (testbench or surrounding datapath)
    modport master (
        output in_valid, in_mode, in_op1, in_op2, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag, busy
    );

    // Multiplier side
    modport slave (
        input  in_valid, in_mode, in_op1, in_op2, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/montgomery_mul_pipe_hs.sv
// rtl/montgomery_mul_pipe_hs.sv - five-stage signed Montgomery multiplier with valid/ready handshake
module montgomery_mul_pipe_hs #(
    parameter int     COEFF_WIDTH = 31,
    parameter int     W           = 32,
    parameter longint Q           = 856145921,
    parameter longint QINV        = 587710463,
    parameter int     TAG_WIDTH   = 8
) (
    input logic                     clk,
    input logic                     rst,
    montgomery_mul_pipe_hs_if.slave bus
);
    localparam int CW = COEFF_WIDTH;
    localparam int PW = 2 * CW;       // op1*op2 product width
    localparam int TW = 2 * W;        // t carried through the pipe
    localparam int MW = W + CW;       // m*Q width
    localparam int SW = 2 * W + 1;    // t + m*Q without overflow
    localparam int RW = W + 1;        // s >>> W, one sign bit plus magnitude

    localparam logic [W-1:0]         QINV_V = W'(QINV);
    localparam logic signed [MW-1:0] Q_M    = MW'(Q);
    localparam logic signed [RW-1:0] Q_R    = RW'(Q);

    // Stage valid bits
    logic v1_q, v2_q, v3_q, v4_q, v5_q;

    // Stage 1: captured operands
    logic                   mode1_q;
    logic signed [CW-1:0]   op1_1_q, op2_1_q;
    logic [TAG_WIDTH-1:0]   tag1_q;
    // Stage 2: full product (or sign-extended op1 in REDUCE mode)
    logic signed [TW-1:0]   t2_q;
    logic [TAG_WIDTH-1:0]   tag2_q;
    // Stage 3: Montgomery quotient m
    logic signed [TW-1:0]   t3_q;
    logic signed [W-1:0]    m3_q;
    logic [TAG_WIDTH-1:0]   tag3_q;
    // Stage 4: m*Q
    logic signed [TW-1:0]   t4_q;
    logic signed [MW-1:0]   mq4_q;
    logic [TAG_WIDTH-1:0]   tag4_q;
    // Stage 5: canonical result
    logic [CW-1:0]          res5_q;
    logic [TAG_WIDTH-1:0]   tag5_q;

    // Next-state values
    logic signed [PW-1:0]   prod2;
    logic signed [TW-1:0]   t2_d;
    logic [W-1:0]           m3_d;
    logic signed [MW-1:0]   mq4_d;
    logic signed [SW-1:0]   s5_sum;
    logic signed [RW-1:0]   r5;
    logic signed [RW-1:0]   res5_full;
    logic [CW-1:0]          res5_d;
    logic                   unused_bits;

    // Whole pipe advances together; it only holds when an unread result sits at the output
    logic en;
    assign en = ~v5_q | bus.out_ready;

    // Datapath: product, quotient, m*Q, then exact divide by 2^W and fold into [0,Q)
    always_comb begin
        prod2     = PW'(op1_1_q) * PW'(op2_1_q);
        t2_d      = mode1_q ? TW'(op1_1_q) : TW'(prod2);
        m3_d      = t2_q[W-1:0] * QINV_V;
        mq4_d     = MW'(m3_q) * Q_M;
        s5_sum    = SW'(t4_q) + SW'(mq4_q);
        r5        = s5_sum[SW-1:W];
        res5_full = r5;
        if (r5[RW-1]) begin
            res5_full = r5 + Q_R;
        end else if (r5 >= Q_R) begin
            res5_full = r5 - Q_R;
        end
        res5_d    = res5_full[CW-1:0];
    end

    // Low half of s is zero by construction and the folded value fits in CW bits
    assign unused_bits = ^{s5_sum[W-1:0], res5_full[RW-1:CW]};

    // Valid bits shift only when the pipe is enabled; reset drops every in-flight operation
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            v3_q <= 1'b0;
            v4_q <= 1'b0;
            v5_q <= 1'b0;
        end else if (en) begin
            v1_q <= bus.in_valid;
            v2_q <= v1_q;
            v3_q <= v2_q;
            v4_q <= v3_q;
            v5_q <= v4_q;
        end
    end

    // Data and tags move in lockstep with the valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode1_q <= 1'b0;
            op1_1_q <= '0;
            op2_1_q <= '0;
            tag1_q  <= '0;
            t2_q    <= '0;
            tag2_q  <= '0;
            t3_q    <= '0;
            m3_q    <= '0;
            tag3_q  <= '0;
            t4_q    <= '0;
            mq4_q   <= '0;
            tag4_q  <= '0;
            res5_q  <= '0;
            tag5_q  <= '0;
        end else if (en) begin
            mode1_q <= bus.in_mode;
            op1_1_q <= bus.in_op1;
            op2_1_q <= bus.in_op2;
            tag1_q  <= bus.in_tag;
            t2_q    <= t2_d;
            tag2_q  <= tag1_q;
            t3_q    <= t2_q;
            m3_q    <= m3_d;
            tag3_q  <= tag2_q;
            t4_q    <= t3_q;
            mq4_q   <= mq4_d;
            tag4_q  <= tag3_q;
            res5_q  <= res5_d;
            tag5_q  <= tag4_q;
        end
    end

    assign bus.in_ready   = en;
    assign bus.out_valid  = v5_q;
    assign bus.out_result = res5_q;
    assign bus.out_tag    = tag5_q;
    assign bus.busy       = v1_q | v2_q | v3_q | v4_q | v5_q;
endmodule

// File: tb/tb_montgomery_mul_pipe_hs.sv
// tb/tb_montgomery_mul_pipe_hs.sv - randomized self-checking bench for montgomery_mul_pipe_hs
module tb_montgomery_mul_pipe_hs;
    localparam int     CW  = 31;
    localparam int     TGW = 8;
    localparam longint Q   = 856145921;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    montgomery_mul_pipe_hs_if #(.COEFF_WIDTH(CW), .TAG_WIDTH(TGW)) bus ();

    montgomery_mul_pipe_hs #(
        .COEFF_WIDTH(CW), .W(32), .Q(Q), .QINV(587710463), .TAG_WIDTH(TGW)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus)
    );

    typedef struct {
        longint         res;
        logic [TGW-1:0] tag;
    } exp_t;

    exp_t           sb[$];
    int             checks = 0;
    int             errors = 0;
    int             pops   = 0;
    logic           acc;
    longint         last_res;
    logic [TGW-1:0] last_tag;
    longint         rinv;

    task automatic chk(input string name, input longint obs, input longint expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, obs, expv);
        end
    endtask

    function automatic longint mod_q(input longint x);
        longint r;
        r = x % Q;
        if (r < 0) r += Q;
        return r;
    endfunction

    function automatic longint inv_mod(input longint a, input longint m);
        longint t, nt, r, nr, qq, tmp;
        t = 0; nt = 1; r = m; nr = a;
        while (nr != 0) begin
            qq = r / nr;
            tmp = t - qq * nt; t = nt; nt = tmp;
            tmp = r - qq * nr; r = nr; nr = tmp;
        end
        if (t < 0) t += m;
        return t;
    endfunction

    // Reference: x * R^-1 mod Q, x = op1*op2 (MUL) or op1 (REDUCE)
    function automatic longint model(input logic mode, input longint a, input longint b);
        longint x;
        x = mode ? mod_q(a) : mod_q(mod_q(a) * mod_q(b));
        return mod_q(x * rinv);
    endfunction

    function automatic longint rand_op();
        longint v;
        case ($urandom_range(15, 0))
            0:       v = Q;
            1:       v = -Q;
            2:       v = 0;
            default: v = longint'($urandom_range(32'd1712291842, 0)) - Q;
        endcase
        return v;
    endfunction

    task automatic drive(input logic mode, input longint a, input longint b,
                         input logic [TGW-1:0] tag, input logic v);
        bus.in_mode  = mode;
        bus.in_op1   = CW'(a);
        bus.in_op2   = CW'(b);
        bus.in_tag   = tag;
        bus.in_valid = v;
    endtask

    // Observe the handshakes that the coming rising edge will complete, then advance one cycle
    task automatic cycle();
        exp_t e;
        #1;
        acc = 1'b0;
        if (rst_n) begin
            chk("in_ready", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
            if (bus.in_valid && bus.in_ready) begin
                e.res = model(bus.in_mode, longint'(bus.in_op1), longint'(bus.in_op2));
                e.tag = bus.in_tag;
                sb.push_back(e);
                acc = 1'b1;
            end
            if (dut.v4_q) chk("s_low_zero", longint'(dut.s5_sum[31:0]), 0);
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 1, 0);
                end else begin
                    chk("result", longint'(bus.out_result), sb[0].res);
                    chk("tag", longint'(bus.out_tag), longint'(sb[0].tag));
                    chk("range", longint'(bus.out_result < Q), 1);
                    if (bus.out_ready) begin
                        last_res = longint'(bus.out_result);
                        last_tag = bus.out_tag;
                        void'(sb.pop_front());
                        pops++;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0) break;
            cycle();
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic run_op(input logic mode, input longint a, input longint b, input logic [TGW-1:0] tag);
        int n;
        bus.out_ready = 1'b1;
        drive(mode, a, b, tag, 1'b1);
        cycle();
        n = 1;
        while (!acc && n < 20) begin
            cycle();
            n++;
        end
        chk("op_accept", longint'(acc), 1);
        drive(1'b0, 0, 0, 8'h00, 1'b0);
        drain();
    endtask

    initial begin
        int     n;
        int     p0;
        int     idx;
        int     stall;
        bit     started;
        int     acc_n;

        rinv = inv_mod(mod_q(longint'(1) << 32), Q);
        drive(1'b0, 0, 0, 8'h00, 1'b0);
        bus.out_ready = 1'b0;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        chk("rst_out_result", longint'(bus.out_result), 0);
        chk("rst_out_tag", longint'(bus.out_tag), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", longint'(bus.in_ready), 1);
        @(negedge clk);

        // Directed: latency and identity multiply
        bus.out_ready = 1'b1;
        drive(1'b0, 14237691, 5, 8'h11, 1'b1);
        cycle();
        chk("t1_accept", longint'(acc), 1);
        drive(1'b0, 0, 0, 8'h00, 1'b0);
        n = 1;
        while (!bus.out_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("t1_latency", n, 5);
        chk("t1_result", longint'(bus.out_result), 5);
        chk("t1_tag", longint'(bus.out_tag), 8'h11);
        drain();

        // Directed: negative operand and Q operand
        run_op(1'b0, 14237691, -5, 8'h22);
        chk("t2_neg", last_res, 856145916);
        chk("t2_neg_tag", longint'(last_tag), 8'h22);
        run_op(1'b0, 14237691, Q, 8'h23);
        chk("t2_q_zero", last_res, 0);
        run_op(1'b0, -Q, Q, 8'h24);
        chk("t2_negq_q", last_res, 0);

        // Directed: REDUCE mode ignores op2
        run_op(1'b1, 14237691, 32'h7FFF_FFFF, 8'h31);
        chk("t3_reduce_one", last_res, 1);
        run_op(1'b1, 0, 12345, 8'h32);
        chk("t3_reduce_zero", last_res, 0);

        // Stream 8 ops, stall the output 6 cycles once the first result appears
        p0 = pops; idx = 0; stall = 6; started = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 200 && (pops - p0) < 8; c++) begin
            drive(1'b0, rand_op(), rand_op(), 8'(idx), idx < 8);
            if (bus.out_valid) started = 1'b1;
            bus.out_ready = !(started && stall > 0);
            if (!bus.out_ready) stall--;
            cycle();
            if (acc) idx++;
        end
        chk("t4_pops", pops - p0, 8);
        chk("t4_stall_used", stall, 0);
        drain();

        // Reset while operations are in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, rand_op(), rand_op(), 8'(8'h50 + i), 1'b1);
            cycle();
            chk("t5_accept", longint'(acc), 1);
        end
        drive(1'b0, 0, 0, 8'h00, 1'b0);
        cycle();
        cycle();
        chk("t5_valid_before", longint'(bus.out_valid), 1);
        chk("t5_busy_before", longint'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_valid_in_reset", longint'(bus.out_valid), 0);
        chk("t5_busy_in_reset", longint'(bus.busy), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t5_no_stale", longint'(bus.out_valid), 0);
        end
        run_op(1'b0, 14237691, 7, 8'h5A);
        chk("t5_recover", last_res, 7);

        // Random traffic with random back-pressure
        acc_n = 0;
        for (int c = 0; c < 80000 && acc_n < 10000; c++) begin
            drive($urandom_range(4, 0) == 0, rand_op(), rand_op(), 8'($urandom), $urandom_range(3, 0) != 0);
            bus.out_ready = $urandom_range(3, 0) != 0;
            cycle();
            if (acc) acc_n++;
        end
        chk("t6_accepts", acc_n, 10000);
        drain();
        chk("t6_idle_busy", longint'(bus.busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
